// File: rtl/xfcp_arb_2.sv
// Two-upstream XFCP request arbiter with a route FIFO that steers each response back
// to the upstream that issued the matching request; unmatched responses are discarded.
module xfcp_arb_2 #(
    parameter int unsigned ROUTE_DEPTH = 4,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic       clk,
    input  logic       rst,

    input  logic [7:0] up0_xfcp_in_tdata,
    input  logic       up0_xfcp_in_tvalid,
    output logic       up0_xfcp_in_tready,
    input  logic       up0_xfcp_in_tlast,
    input  logic       up0_xfcp_in_tuser,
    output logic [7:0] up0_xfcp_out_tdata,
    output logic       up0_xfcp_out_tvalid,
    input  logic       up0_xfcp_out_tready,
    output logic       up0_xfcp_out_tlast,
    output logic       up0_xfcp_out_tuser,

    input  logic [7:0] up1_xfcp_in_tdata,
    input  logic       up1_xfcp_in_tvalid,
    output logic       up1_xfcp_in_tready,
    input  logic       up1_xfcp_in_tlast,
    input  logic       up1_xfcp_in_tuser,
    output logic [7:0] up1_xfcp_out_tdata,
    output logic       up1_xfcp_out_tvalid,
    input  logic       up1_xfcp_out_tready,
    output logic       up1_xfcp_out_tlast,
    output logic       up1_xfcp_out_tuser,

    output logic [7:0] down_xfcp_out_tdata,
    output logic       down_xfcp_out_tvalid,
    input  logic       down_xfcp_out_tready,
    output logic       down_xfcp_out_tlast,
    output logic       down_xfcp_out_tuser,
    input  logic [7:0] down_xfcp_in_tdata,
    input  logic       down_xfcp_in_tvalid,
    output logic       down_xfcp_in_tready,
    input  logic       down_xfcp_in_tlast,
    input  logic       down_xfcp_in_tuser,

    output logic       rsp_drop,
    output logic       rsp_timeout
);

    localparam int unsigned AW = (ROUTE_DEPTH > 2) ? $clog2(ROUTE_DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT    = (AW + 1)'(ROUTE_DEPTH);
    localparam logic [AW:0]   CNT_ONE     = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [15:0]   TIMEOUT_VAL = 16'(TIMEOUT);
    localparam bit            TIMEOUT_EN  = (TIMEOUT != 0);

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACTIVE = 1'b1
    } arb_state_e;

    arb_state_e              r_state;
    logic                    r_grant;
    logic                    r_last_grant;
    logic [ROUTE_DEPTH-1:0]  r_fifo;
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_count;
    logic                    r_drop;
    logic                    r_rsp_active;
    logic [15:0]             r_timer;

    logic w_empty, w_full, w_head;
    logic w_grant_port, w_push, w_active;
    logic w_sel_valid, w_sel_last, w_req_done;
    logic w_drop_path, w_route_ready;
    logic w_rsp_fire, w_rsp_pop, w_drop_fire, w_timeout, w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_head  = r_fifo[r_rd_ptr];

    // Lone requester wins outright; on contention the port not granted last wins.
    assign w_grant_port = (up0_xfcp_in_tvalid && up1_xfcp_in_tvalid) ? ~r_last_grant
                                                                     : up1_xfcp_in_tvalid;
    assign w_push = (r_state == ARB_IDLE) && !w_full &&
                    (up0_xfcp_in_tvalid || up1_xfcp_in_tvalid);
    assign w_active = (r_state == ARB_ACTIVE) && !rst;

    assign w_sel_valid = r_grant ? up1_xfcp_in_tvalid : up0_xfcp_in_tvalid;
    assign w_sel_last  = r_grant ? up1_xfcp_in_tlast  : up0_xfcp_in_tlast;
    assign w_req_done  = w_active && w_sel_valid && down_xfcp_out_tready && w_sel_last;

    assign down_xfcp_out_tdata  = r_grant ? up1_xfcp_in_tdata : up0_xfcp_in_tdata;
    assign down_xfcp_out_tuser  = r_grant ? up1_xfcp_in_tuser : up0_xfcp_in_tuser;
    assign down_xfcp_out_tlast  = w_sel_last;
    assign down_xfcp_out_tvalid = w_active && w_sel_valid;
    assign up0_xfcp_in_tready   = w_active && !r_grant && down_xfcp_out_tready;
    assign up1_xfcp_in_tready   = w_active &&  r_grant && down_xfcp_out_tready;

    // With nothing to route to, responses are swallowed until their tlast.
    assign w_drop_path   = r_drop || w_empty;
    assign w_route_ready = w_head ? up1_xfcp_out_tready : up0_xfcp_out_tready;
    assign down_xfcp_in_tready = rst || w_drop_path || w_route_ready;

    assign up0_xfcp_out_tdata  = down_xfcp_in_tdata;
    assign up0_xfcp_out_tlast  = down_xfcp_in_tlast;
    assign up0_xfcp_out_tuser  = down_xfcp_in_tuser;
    assign up1_xfcp_out_tdata  = down_xfcp_in_tdata;
    assign up1_xfcp_out_tlast  = down_xfcp_in_tlast;
    assign up1_xfcp_out_tuser  = down_xfcp_in_tuser;
    assign up0_xfcp_out_tvalid = !rst && !w_drop_path && !w_head && down_xfcp_in_tvalid;
    assign up1_xfcp_out_tvalid = !rst && !w_drop_path &&  w_head && down_xfcp_in_tvalid;

    assign w_rsp_fire  = !rst && !w_drop_path && down_xfcp_in_tvalid && w_route_ready;
    assign w_rsp_pop   = w_rsp_fire && down_xfcp_in_tlast;
    assign w_drop_fire = !rst && w_drop_path && down_xfcp_in_tvalid;
    assign rsp_drop    = w_drop_fire && down_xfcp_in_tlast;

    // Only retire an idle head: never while a response to it is moving.
    assign w_timeout = TIMEOUT_EN && !rst && !w_empty && !r_rsp_active && !r_drop &&
                       !w_rsp_fire && (r_timer == TIMEOUT_VAL);
    assign rsp_timeout = w_timeout;
    assign w_pop       = w_rsp_pop || w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;  // makes port 0 the first contention winner
            r_fifo       <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_drop       <= 1'b0;
            r_rsp_active <= 1'b0;
            r_timer      <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_push) begin
                        r_grant <= w_grant_port;
                        r_state <= ARB_ACTIVE;
                    end
                end
                ARB_ACTIVE: begin
                    if (w_req_done) begin
                        r_last_grant <= r_grant;
                        r_state      <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase

            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_grant_port;
                r_wr_ptr         <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_ONE;
            end

            if (w_drop_fire) begin
                r_drop <= !down_xfcp_in_tlast;
            end
            if (w_rsp_fire) begin
                r_rsp_active <= !down_xfcp_in_tlast;
            end

            if (w_rsp_fire || w_drop_fire || w_pop || w_empty) begin
                r_timer <= '0;
            end else if (!r_rsp_active && !r_drop) begin
                r_timer <= r_timer + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_xfcp_arb_2.sv
// Directed bench for xfcp_arb_2: main instance with default parameters plus a
// second instance with a short timeout for the retirement path.
module tb_xfcp_arb_2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] u0_tdata, u1_tdata, o0_tdata, o1_tdata, do_tdata, di_tdata;
    logic u0_tvalid, u0_tready, u0_tlast, u0_tuser;
    logic u1_tvalid, u1_tready, u1_tlast, u1_tuser;
    logic o0_tvalid, o0_tready, o0_tlast, o0_tuser;
    logic o1_tvalid, o1_tready, o1_tlast, o1_tuser;
    logic do_tvalid, do_tready, do_tlast, do_tuser;
    logic di_tvalid, di_tready, di_tlast, di_tuser;
    logic rsp_drop, rsp_timeout;

    // short-timeout instance
    logic t_u0_tvalid, t_u0_tready, t_u1_tready, t_do_tvalid;
    logic t_di_tvalid, t_di_tready, t_di_tlast;
    logic t_o0_tvalid, t_o1_tvalid, t_drop, t_tmo;
    logic [7:0] t_o0_tdata, t_o1_tdata, t_do_tdata;
    logic t_o0_tlast, t_o0_tuser, t_o1_tlast, t_o1_tuser, t_do_tlast, t_do_tuser;

    int n_checks = 0;
    int n_errors = 0;

    xfcp_arb_2 dut (
        .clk(clk), .rst(rst),
        .up0_xfcp_in_tdata(u0_tdata), .up0_xfcp_in_tvalid(u0_tvalid),
        .up0_xfcp_in_tready(u0_tready), .up0_xfcp_in_tlast(u0_tlast),
        .up0_xfcp_in_tuser(u0_tuser),
        .up0_xfcp_out_tdata(o0_tdata), .up0_xfcp_out_tvalid(o0_tvalid),
        .up0_xfcp_out_tready(o0_tready), .up0_xfcp_out_tlast(o0_tlast),
        .up0_xfcp_out_tuser(o0_tuser),
        .up1_xfcp_in_tdata(u1_tdata), .up1_xfcp_in_tvalid(u1_tvalid),
        .up1_xfcp_in_tready(u1_tready), .up1_xfcp_in_tlast(u1_tlast),
        .up1_xfcp_in_tuser(u1_tuser),
        .up1_xfcp_out_tdata(o1_tdata), .up1_xfcp_out_tvalid(o1_tvalid),
        .up1_xfcp_out_tready(o1_tready), .up1_xfcp_out_tlast(o1_tlast),
        .up1_xfcp_out_tuser(o1_tuser),
        .down_xfcp_out_tdata(do_tdata), .down_xfcp_out_tvalid(do_tvalid),
        .down_xfcp_out_tready(do_tready), .down_xfcp_out_tlast(do_tlast),
        .down_xfcp_out_tuser(do_tuser),
        .down_xfcp_in_tdata(di_tdata), .down_xfcp_in_tvalid(di_tvalid),
        .down_xfcp_in_tready(di_tready), .down_xfcp_in_tlast(di_tlast),
        .down_xfcp_in_tuser(di_tuser),
        .rsp_drop(rsp_drop), .rsp_timeout(rsp_timeout)
    );

    xfcp_arb_2 #(.ROUTE_DEPTH(4), .TIMEOUT(10)) dut_to (
        .clk(clk), .rst(rst),
        .up0_xfcp_in_tdata(8'h42), .up0_xfcp_in_tvalid(t_u0_tvalid),
        .up0_xfcp_in_tready(t_u0_tready), .up0_xfcp_in_tlast(1'b1),
        .up0_xfcp_in_tuser(1'b0),
        .up0_xfcp_out_tdata(t_o0_tdata), .up0_xfcp_out_tvalid(t_o0_tvalid),
        .up0_xfcp_out_tready(1'b1), .up0_xfcp_out_tlast(t_o0_tlast),
        .up0_xfcp_out_tuser(t_o0_tuser),
        .up1_xfcp_in_tdata(8'h00), .up1_xfcp_in_tvalid(1'b0),
        .up1_xfcp_in_tready(t_u1_tready), .up1_xfcp_in_tlast(1'b0),
        .up1_xfcp_in_tuser(1'b0),
        .up1_xfcp_out_tdata(t_o1_tdata), .up1_xfcp_out_tvalid(t_o1_tvalid),
        .up1_xfcp_out_tready(1'b1), .up1_xfcp_out_tlast(t_o1_tlast),
        .up1_xfcp_out_tuser(t_o1_tuser),
        .down_xfcp_out_tdata(t_do_tdata), .down_xfcp_out_tvalid(t_do_tvalid),
        .down_xfcp_out_tready(1'b1), .down_xfcp_out_tlast(t_do_tlast),
        .down_xfcp_out_tuser(t_do_tuser),
        .down_xfcp_in_tdata(8'h77), .down_xfcp_in_tvalid(t_di_tvalid),
        .down_xfcp_in_tready(t_di_tready), .down_xfcp_in_tlast(t_di_tlast),
        .down_xfcp_in_tuser(1'b0),
        .rsp_drop(t_drop), .rsp_timeout(t_tmo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        u0_tdata = 8'h00; u0_tvalid = 1'b0; u0_tlast = 1'b0; u0_tuser = 1'b0;
        u1_tdata = 8'h00; u1_tvalid = 1'b0; u1_tlast = 1'b0; u1_tuser = 1'b0;
        di_tdata = 8'h00; di_tvalid = 1'b0; di_tlast = 1'b0; di_tuser = 1'b0;
        do_tready = 1'b1; o0_tready = 1'b1; o1_tready = 1'b1;
        t_u0_tvalid = 1'b0; t_di_tvalid = 1'b0; t_di_tlast = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    // 3-byte request on up0, 2-byte response, then a stray beat proves the FIFO drained.
    task automatic run_basic();
        u0_tvalid = 1'b1; u0_tdata = 8'h11; u0_tlast = 1'b0;
        @(negedge clk);
        check("basic_idle_tready", u0_tready, 1'b0);
        check("basic_idle_tvalid", do_tvalid, 1'b0);
        nxt();
        @(negedge clk);
        check("basic_b0_valid", do_tvalid, 1'b1);
        check("basic_b0_data", do_tdata, 8'h11);
        check("basic_b0_ready", u0_tready, 1'b1);
        check("basic_b0_u1ready", u1_tready, 1'b0);
        nxt();
        u0_tdata = 8'h22;
        @(negedge clk);
        check("basic_b1_data", do_tdata, 8'h22);
        nxt();
        u0_tdata = 8'h33; u0_tlast = 1'b1;
        @(negedge clk);
        check("basic_b2_data", do_tdata, 8'h33);
        check("basic_b2_last", do_tlast, 1'b1);
        nxt();
        u0_tvalid = 1'b0; u0_tlast = 1'b0;
        di_tvalid = 1'b1; di_tdata = 8'hA1; di_tlast = 1'b0;
        @(negedge clk);
        check("basic_after_valid", do_tvalid, 1'b0);
        check("basic_r0_o0valid", o0_tvalid, 1'b1);
        check("basic_r0_o1valid", o1_tvalid, 1'b0);
        check("basic_r0_data", o0_tdata, 8'hA1);
        check("basic_r0_ready", di_tready, 1'b1);
        nxt();
        di_tdata = 8'hA2; di_tlast = 1'b1;
        @(negedge clk);
        check("basic_r1_o0valid", o0_tvalid, 1'b1);
        check("basic_r1_last", o0_tlast, 1'b1);
        nxt();
        di_tdata = 8'hEE;
        @(negedge clk);
        check("basic_empty_o0valid", o0_tvalid, 1'b0);
        check("basic_empty_drop", rsp_drop, 1'b1);
        nxt();
        di_tvalid = 1'b0; di_tlast = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int bi0, fi0, bi1, fi1, k, cyc, f, pulses, pulse_cyc;
        logic acc0, acc1;
        logic [7:0] exp_d;

        // Reset behaviour with requests/responses pending
        clear_inputs();
        rst = 1'b1;
        u0_tvalid = 1'b1; di_tvalid = 1'b1;
        nxt();
        @(negedge clk);
        check("rst_u0_tready", u0_tready, 1'b0);
        check("rst_do_tvalid", do_tvalid, 1'b0);
        check("rst_o0_tvalid", o0_tvalid, 1'b0);
        check("rst_drop", rsp_drop, 1'b0);
        check("rst_timeout", rsp_timeout, 1'b0);
        nxt();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        check("post_rst_u0_tready", u0_tready, 1'b0);
        check("post_rst_do_tvalid", do_tvalid, 1'b0);
        check("post_rst_o1_tvalid", o1_tvalid, 1'b0);
        nxt();

        run_basic();

        // Round-robin with both ports streaming 4-byte frames: data = {port, frame, beat}
        do_reset();
        bi0 = 0; fi0 = 0; bi1 = 0; fi1 = 0; k = 0; cyc = 0;
        while (k < 16 && cyc < 60) begin
            u0_tvalid = 1'b1; u0_tdata = {1'b0, fi0[2:0], bi0[3:0]}; u0_tlast = (bi0 == 3);
            u1_tvalid = 1'b1; u1_tdata = {1'b1, fi1[2:0], bi1[3:0]}; u1_tlast = (bi1 == 3);
            @(negedge clk);
            if (do_tvalid && do_tready) begin
                f = k / 4;
                exp_d = {f[0], 3'(f / 2), 4'(k % 4)};
                check("rr_data", do_tdata, exp_d);
                check("rr_last", do_tlast, (k % 4) == 3);
                k++;
            end
            acc0 = u0_tvalid && u0_tready;
            acc1 = u1_tvalid && u1_tready;
            nxt();
            cyc++;
            if (acc0) begin bi0++; if (bi0 == 4) begin bi0 = 0; fi0++; end end
            if (acc1) begin bi1++; if (bi1 == 4) begin bi1 = 0; fi1++; end end
        end
        check("rr_beats", k, 16);
        check("rr_cycles", cyc, 20);

        // Route FIFO now holds 4 entries: the 5th frame must wait for a response pop
        u0_tdata = 8'h20; u0_tlast = 1'b0;
        u1_tdata = 8'hA0; u1_tlast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_no_grant", do_tvalid, 1'b0);
            check("full_u0_tready", u0_tready, 1'b0);
            nxt();
        end
        di_tvalid = 1'b1; di_tlast = 1'b1; di_tdata = 8'h55;
        @(negedge clk);
        check("full_rsp_o0", o0_tvalid, 1'b1);
        check("full_rsp_o1", o1_tvalid, 1'b0);
        nxt();
        di_tvalid = 1'b0;
        @(negedge clk);
        check("full_grant_cycle", do_tvalid, 1'b0);
        nxt();
        @(negedge clk);
        check("full_5th_valid", do_tvalid, 1'b1);
        check("full_5th_data", do_tdata, 8'h20);
        nxt();
        di_tvalid = 1'b1; di_tlast = 1'b1;
        @(negedge clk);
        check("head1_o1", o1_tvalid, 1'b1);
        check("head1_o0", o0_tvalid, 1'b0);
        nxt();

        // Response on empty FIFO; a push mid-frame must not end the drop
        do_reset();
        di_tvalid = 1'b1; di_tdata = 8'hD0; di_tlast = 1'b0;
        u0_tvalid = 1'b1; u0_tdata = 8'h01; u0_tlast = 1'b1;
        @(negedge clk);
        check("drop_b0_ready", di_tready, 1'b1);
        check("drop_b0_o0", o0_tvalid, 1'b0);
        check("drop_b0_pulse", rsp_drop, 1'b0);
        nxt();
        di_tdata = 8'hD1;
        @(negedge clk);
        check("drop_b1_ready", di_tready, 1'b1);
        check("drop_b1_o0", o0_tvalid, 1'b0);
        check("drop_b1_pulse", rsp_drop, 1'b0);
        nxt();
        u0_tvalid = 1'b0; u0_tlast = 1'b0;
        di_tdata = 8'hD2; di_tlast = 1'b1;
        @(negedge clk);
        check("drop_b2_ready", di_tready, 1'b1);
        check("drop_b2_o0", o0_tvalid, 1'b0);
        check("drop_b2_o1", o1_tvalid, 1'b0);
        check("drop_b2_pulse", rsp_drop, 1'b1);
        nxt();
        di_tdata = 8'h5A;
        @(negedge clk);
        check("drop_then_route_o0", o0_tvalid, 1'b1);
        check("drop_then_route_data", o0_tdata, 8'h5A);
        check("drop_then_no_pulse", rsp_drop, 1'b0);
        nxt();
        di_tvalid = 1'b0; di_tlast = 1'b0;

        // Timeout instance: head retired 10 cycles after its counter starts
        do_reset();
        t_u0_tvalid = 1'b1;
        nxt();
        pulses = 0; pulse_cyc = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (t_tmo) begin
                pulses++;
                pulse_cyc = c;
            end
            nxt();
            if (c == 1) t_u0_tvalid = 1'b0;
        end
        check("tmo_pulses", pulses, 1);
        check("tmo_cycle", pulse_cyc, 11);
        t_di_tvalid = 1'b1; t_di_tlast = 1'b1;
        @(negedge clk);
        check("tmo_late_drop", t_drop, 1'b1);
        check("tmo_late_o0", t_o0_tvalid, 1'b0);
        nxt();
        t_di_tvalid = 1'b0; t_di_tlast = 1'b0;

        // Reset mid-request and mid-response under random backpressure
        do_reset();
        for (int i = 0; i < 8; i++) begin
            u0_tvalid = 1'b1; u0_tlast = 1'b0; u0_tdata = 8'(i);
            di_tvalid = 1'b1; di_tlast = 1'b0; di_tdata = 8'(8'h80 + i);
            do_tready = 1'($urandom_range(0, 1));
            o0_tready = 1'($urandom_range(0, 1));
            nxt();
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_u0_tready", u0_tready, 1'b0);
        check("midrst_u1_tready", u1_tready, 1'b0);
        check("midrst_do_tvalid", do_tvalid, 1'b0);
        check("midrst_o0_tvalid", o0_tvalid, 1'b0);
        check("midrst_o1_tvalid", o1_tvalid, 1'b0);
        check("midrst_drop", rsp_drop, 1'b0);
        check("midrst_timeout", rsp_timeout, 1'b0);
        nxt();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        check("after_midrst_u0_tready", u0_tready, 1'b0);
        check("after_midrst_do_tvalid", do_tvalid, 1'b0);
        check("after_midrst_o0_tvalid", o0_tvalid, 1'b0);
        nxt();
        run_basic();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
